asp_mmio64_dfh_responder: RTL and testbench

- Avalon-MM MMIO responder (AFU side) for child host-channel links.
- Terminates host MMIO reads and writes that the PIM presents on a 64-bit MMIO sink, so every request gets a well-formed response.
- Implements a minimal DFH/GUID header, a scratch register, access counters and a protocol-error flag.
- Sits behind the PIM's MMIO interface for each child link; the primary link keeps its full MMIO path into the kernel system.

---
 rtl/asp_mmio64_dfh_responder.sv | 172 +++++++++++++++++
 tb/tb_asp_mmio64_dfh_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asp_mmio64_dfh_responder.sv
// asp_mmio64_dfh_responder
// Avalon-MM MMIO terminator for child host-channel links. It answers every
// host read and absorbs every host write. It exposes a minimal DFH/GUID header,
// a byte-enabled scratch register, saturating access counters and a sticky
// flag that records read and write being asserted in the same cycle.
module asp_mmio64_dfh_responder #(
  parameter int          ADDR_WIDTH   = 7,
  parameter int          DATA_WIDTH   = 64,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] GUID_H       = 64'h0,
  parameter logic [63:0] GUID_L       = 64'h0,
  parameter logic [11:0] FEATURE_ID   = 12'h000,
  parameter logic [3:0]  DFH_REV      = 4'h0
) (
  input  logic                      pClk,
  input  logic                      pClk_reset,
  input  logic [ADDR_WIDTH-1:0]     avmm_address,
  input  logic                      avmm_read,
  input  logic                      avmm_write,
  input  logic [DATA_WIDTH-1:0]     avmm_writedata,
  input  logic [DATA_WIDTH/8-1:0]   avmm_byteenable,
  output logic                      avmm_waitrequest,
  output logic [DATA_WIDTH-1:0]     avmm_readdata,
  output logic                      avmm_readdatavalid,
  output logic                      err_rdwr_sticky,
  output logic [DATA_WIDTH-1:0]     scratch_out
);

  localparam int BE_W = DATA_WIDTH / 8;

  // Register map (64-bit word addresses)
  localparam logic [ADDR_WIDTH-1:0] ADDR_DFH     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_GUID_L  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_GUID_H  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SCRATCH = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(6);

  // DFH: type nibble 1, end-of-list bit 40, revision and feature ID at the bottom
  localparam logic [63:0] DFH_VALUE = {4'h1, 19'h0, 1'b1, 24'h0, DFH_REV, FEATURE_ID};

  // Only the 64-bit data path and latencies 1..4 are meaningful
  generate
    if (DATA_WIDTH != 64 || READ_LATENCY < 1 || READ_LATENCY > 4 || ADDR_WIDTH < 3) begin : g_bad_param
      $error("asp_mmio64_dfh_responder: unsupported parameter combination");
    end
  endgenerate

  logic                    wait_q;
  logic [DATA_WIDTH-1:0]   scratch_q, scratch_d;
  logic [31:0]             rd_count_q, rd_count_d;
  logic [31:0]             wr_count_q, wr_count_d;
  logic                    err_q, err_d;

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];

  logic                    waitreq;
  logic                    req_acc;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    conflict;
  logic                    ctrl_wr;
  logic                    cnt_clr;
  logic                    err_clr;
  logic [DATA_WIDTH-1:0]   rd_mux;

  // Stall while reset is asserted and for the first cycle after it drops
  assign waitreq  = wait_q | pClk_reset;
  assign req_acc  = !waitreq && (avmm_read || avmm_write);
  assign rd_acc   = req_acc && avmm_read;
  // A simultaneous read and write keeps the read and drops the write
  assign conflict = req_acc && avmm_read && avmm_write;
  assign wr_acc   = req_acc && avmm_write && !avmm_read;
  assign ctrl_wr  = wr_acc && (avmm_address == ADDR_CTRL);
  assign cnt_clr  = ctrl_wr && avmm_writedata[0];
  assign err_clr  = ctrl_wr && avmm_writedata[1];

  // Read data reflects register state before any same-cycle update
  always_comb begin
    rd_mux = '0;
    case (avmm_address)
      ADDR_DFH:     rd_mux = DFH_VALUE;
      ADDR_GUID_L:  rd_mux = GUID_L;
      ADDR_GUID_H:  rd_mux = GUID_H;
      ADDR_SCRATCH: rd_mux = scratch_q;
      ADDR_STATUS:  rd_mux = {rd_count_q, wr_count_q};
      default:      rd_mux = '0;
    endcase
  end

  // Next-state for scratch, counters and sticky error flag
  always_comb begin
    scratch_d  = scratch_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;

    if (wr_acc && (avmm_address == ADDR_SCRATCH)) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avmm_byteenable[b]) begin
          scratch_d[b*8 +: 8] = avmm_writedata[b*8 +: 8];
        end
      end
    end

    // Counters saturate instead of wrapping
    if (rd_acc && (rd_count_q != 32'hFFFF_FFFF)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (wr_acc && !cnt_clr && (wr_count_q != 32'hFFFF_FFFF)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
    // Clearing beats any increment in the same cycle
    if (cnt_clr) begin
      rd_count_d = '0;
      wr_count_d = '0;
    end

    if (conflict) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      wait_q     <= 1'b1;
      scratch_q  <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_q     <= 1'b0;
      scratch_q  <= scratch_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Fixed-latency read pipeline; a stage's data only moves with a valid,
  // so the last stage holds the previous response between strobes
  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        data_q[0] <= rd_mux;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign avmm_waitrequest   = waitreq;
  assign avmm_readdatavalid = vld_q[READ_LATENCY-1];
  assign avmm_readdata      = data_q[READ_LATENCY-1];
  assign err_rdwr_sticky    = err_q;
  assign scratch_out        = scratch_q;

endmodule

// File: tb/tb_asp_mmio64_dfh_responder.sv
// Bench for asp_mmio64_dfh_responder: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a queue-based behavioural model of the register file.
module tb_asp_mmio64_dfh_responder;

  localparam int          AW    = 7;
  localparam int          LAT   = 2;
  localparam logic [63:0] G_L   = 64'hA;
  localparam logic [63:0] G_H   = 64'hB;
  localparam logic [11:0] FID   = 12'h0AB;
  localparam logic [3:0]  REV   = 4'h2;

  logic          pClk = 1'b0;
  logic          pClk_reset = 1'b1;
  logic [AW-1:0] avmm_address = '0;
  logic          avmm_read = 1'b0;
  logic          avmm_write = 1'b0;
  logic [63:0]   avmm_writedata = '0;
  logic [7:0]    avmm_byteenable = '0;
  logic          avmm_waitrequest;
  logic [63:0]   avmm_readdata;
  logic          avmm_readdatavalid;
  logic          err_rdwr_sticky;
  logic [63:0]   scratch_out;

  always #5 pClk = ~pClk;

  asp_mmio64_dfh_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(64), .READ_LATENCY(LAT),
    .GUID_H(G_H), .GUID_L(G_L), .FEATURE_ID(FID), .DFH_REV(REV)
  ) dut (
    .pClk(pClk), .pClk_reset(pClk_reset),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .err_rdwr_sticky(err_rdwr_sticky),
    .scratch_out(scratch_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [63:0] data; } resp_t;
  resp_t       pend_q[$];
  logic [63:0] got_q[$];
  bit          m_wait = 1'b1;
  logic [63:0] m_scratch = '0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_wr = '0;
  bit          m_err = 1'b0;
  bit          m_rvld = 1'b0;
  logic [63:0] m_rdata = '0;
  int          edge_n = 0;

  function automatic logic [63:0] m_read(input logic [AW-1:0] a);
    case (a)
      7'd0:    return {4'h1, 19'h0, 1'b1, 24'h0, REV, FID};
      7'd1:    return G_L;
      7'd2:    return G_H;
      7'd4:    return m_scratch;
      7'd5:    return {m_rd, m_wr};
      default: return 64'h0;
    endcase
  endfunction

  // Model advances on every rising edge from the inputs presented before it
  always @(posedge pClk) begin : model
    bit          acc;
    logic [63:0] rdat;
    edge_n++;
    if (pClk_reset) begin
      m_wait = 1'b1; m_scratch = '0; m_rd = '0; m_wr = '0; m_err = 1'b0;
      m_rvld = 1'b0; m_rdata = '0;
      pend_q.delete();
    end else begin
      acc = !m_wait && (avmm_read || avmm_write);
      if (acc && avmm_read) begin
        rdat = m_read(avmm_address);
        pend_q.push_back('{edge_n + LAT - 1, rdat});
        if (m_rd != 32'hFFFF_FFFF) m_rd++;
        if (avmm_write) m_err = 1'b1;
      end else if (acc && avmm_write) begin
        if (avmm_address == 7'd4) begin
          for (int b = 0; b < 8; b++)
            if (avmm_byteenable[b]) m_scratch[b*8 +: 8] = avmm_writedata[b*8 +: 8];
        end
        if (avmm_address == 7'd6 && avmm_writedata[1]) m_err = 1'b0;
        if (avmm_address == 7'd6 && avmm_writedata[0]) begin
          m_rd = '0; m_wr = '0;
        end else if (m_wr != 32'hFFFF_FFFF) begin
          m_wr++;
        end
      end
      m_wait = 1'b0;
      m_rvld = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
        m_rvld  = 1'b1;
        m_rdata = pend_q[0].data;
        void'(pend_q.pop_front());
      end
    end
  end

  // Compare process: every output on every falling edge
  always @(negedge pClk) begin
    if (edge_n > 0) begin
      chk("waitrequest", 64'(avmm_waitrequest), 64'(m_wait | pClk_reset));
      chk("readdatavalid", 64'(avmm_readdatavalid), 64'(m_rvld));
      chk("readdata", avmm_readdata, m_rdata);
      chk("scratch_out", scratch_out, m_scratch);
      chk("err_rdwr_sticky", 64'(err_rdwr_sticky), 64'(m_err));
      if (avmm_readdatavalid) begin
        got_q.push_back(avmm_readdata);
        $display("[%0t] read response data=%h", $time, avmm_readdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [63:0] d, input logic [7:0] be);
    avmm_read = rd; avmm_write = wr; avmm_address = a;
    avmm_writedata = d; avmm_byteenable = be;
    if (rd || wr) $display("[%0t] request rd=%0d wr=%0d addr=%h data=%h be=%h",
                           $time, rd, wr, a, d, be);
    @(posedge pClk); #2;
    avmm_read = 1'b0; avmm_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pClk); #2; end
  endtask

  // Issue one read (optionally with a conflicting write) and wait, bounded, for its response
  task automatic rd_wait(input logic [AW-1:0] a, input bit wr,
                         output int lat, output logic [63:0] d);
    cyc(1'b1, wr, a, 64'h0, 8'hFF);
    lat = 0;
    d   = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge pClk);
      if (avmm_readdatavalid) begin
        lat = k;
        d   = avmm_readdata;
        break;
      end
    end
    @(posedge pClk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [63:0] d;
    int          sel;
    logic [AW-1:0] a;
    bit          rd, wr;

    // Reset and waitrequest release timing
    repeat (3) @(posedge pClk);
    #2;
    chk("reset_readdata", avmm_readdata, 64'h0);
    chk("reset_rdv", 64'(avmm_readdatavalid), 64'h0);
    pClk_reset = 1'b0;
    @(negedge pClk);
    chk("wait_first_cycle", 64'(avmm_waitrequest), 64'h1);
    @(posedge pClk); #2;
    chk("wait_second_cycle", 64'(avmm_waitrequest), 64'h0);

    // DFH read and latency
    rd_wait(7'h0, 1'b0, lat, d);
    chk("dfh_latency", 64'(lat), 64'd2);
    chk("dfh_value", d, 64'h1000_0100_0000_20AB);

    // Byte-enabled scratch writes
    cyc(1'b0, 1'b1, 7'h4, 64'h1122334455667788, 8'hFF);
    cyc(1'b0, 1'b1, 7'h4, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    cyc(1'b0, 1'b1, 7'h4, 64'h0, 8'h00);
    rd_wait(7'h4, 1'b0, lat, d);
    chk("scratch_read", d, 64'h11223344FFFFFFFF);
    chk("scratch_out_lit", scratch_out, 64'h11223344FFFFFFFF);

    // Back-to-back reads after a counter clear
    cyc(1'b0, 1'b1, 7'h6, 64'h1, 8'hFF);
    got_q.delete();
    cyc(1'b1, 1'b0, 7'h1, 64'h0, 8'h00);
    cyc(1'b1, 1'b0, 7'h2, 64'h0, 8'h00);
    cyc(1'b1, 1'b0, 7'h3, 64'h0, 8'h00);
    cyc(1'b1, 1'b0, 7'h7F, 64'h0, 8'h00);
    idle(4);
    chk("burst_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("burst_guid_l", got_q[0], 64'hA);
      chk("burst_guid_h", got_q[1], 64'hB);
      chk("burst_rsvd", got_q[2], 64'h0);
      chk("burst_unmapped", got_q[3], 64'h0);
    end
    rd_wait(7'h5, 1'b0, lat, d);
    chk("status_after_burst", d, {32'd4, 32'd0});

    // Read/write conflict on scratch
    rd_wait(7'h4, 1'b1, lat, d);
    chk("conflict_read_old", d, 64'h11223344FFFFFFFF);
    chk("conflict_scratch_kept", scratch_out, 64'h11223344FFFFFFFF);
    chk("conflict_err_set", 64'(err_rdwr_sticky), 64'h1);
    cyc(1'b0, 1'b1, 7'h6, 64'h2, 8'hFF);
    @(negedge pClk);
    chk("err_cleared", 64'(err_rdwr_sticky), 64'h0);
    @(posedge pClk); #2;
    rd_wait(7'h5, 1'b0, lat, d);
    chk("status_after_conflict", d, {32'd6, 32'd1});

    // Saturation from a preloaded counter state
    idle(3);
    @(negedge pClk);
    force dut.rd_count_q = 32'hFFFF_FFFE;
    force dut.wr_count_q = 32'hFFFF_FFFE;
    m_rd = 32'hFFFF_FFFE;
    m_wr = 32'hFFFF_FFFE;
    @(posedge pClk);
    @(negedge pClk);
    release dut.rd_count_q;
    release dut.wr_count_q;
    @(posedge pClk); #2;
    repeat (3) cyc(1'b1, 1'b0, 7'h0, 64'h0, 8'h00);
    repeat (2) cyc(1'b0, 1'b1, 7'h3, 64'h0, 8'hFF);
    idle(3);
    rd_wait(7'h5, 1'b0, lat, d);
    chk("status_saturated", d, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    cyc(1'b0, 1'b1, 7'h6, 64'h1, 8'hFF);
    rd_wait(7'h5, 1'b0, lat, d);
    chk("status_cleared", d, 64'h0);

    // Reset while a read is in flight
    cyc(1'b1, 1'b1, 7'h4, 64'h0, 8'hFF);
    idle(3);
    got_q.delete();
    cyc(1'b1, 1'b0, 7'h2, 64'h0, 8'h00);
    pClk_reset = 1'b1;
    idle(3);
    pClk_reset = 1'b0;
    @(negedge pClk);
    chk("rst_wait_high", 64'(avmm_waitrequest), 64'h1);
    chk("rst_readdata", avmm_readdata, 64'h0);
    chk("rst_scratch", scratch_out, 64'h0);
    chk("rst_err", 64'(err_rdwr_sticky), 64'h0);
    @(posedge pClk); #2;
    idle(5);
    chk("rst_no_response", 64'(got_q.size()), 64'd0);

    // Randomized traffic, including conflicts, CTRL writes and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pClk_reset = 1'b1;
        idle(2);
        pClk_reset = 1'b0;
      end else begin
        sel = $urandom_range(0, 9);
        rd  = (sel <= 3) || (sel == 8);
        wr  = (sel >= 4 && sel <= 8);
        a   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        d   = {$urandom, $urandom};
        if (a == 7'd6 && $urandom_range(0, 1) == 0) d = 64'h0;
        cyc(rd, wr, a, d, 8'($urandom));
      end
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
